// File: rtl/chord_seq_pkg.sv
// Shared types and song-ROM field layout for the chord sequencer.
package chord_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_GAP,
    S_PLAY,
    S_DONE
  } seq_state_t;

  localparam int LAST_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;

  localparam logic [5:0] END_DURATION = 6'd0;

endpackage

// File: rtl/chord_sequencer.sv
// Walks the song ROM and loads each chord into the player; all outputs registered, 4 cycles per note.
// play=0 pauses in place; CHORD_SEQ_LOOP_EN restarts the song from address 0 instead of stopping.
module chord_sequencer
  import chord_seq_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_NOTES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [15:0]       rom_data,
  input  logic              note_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [5:0]        note_to_load,
  output logic [5:0]        duration,
  output logic              load_new_note,
  output logic              activate,
  output logic [1:0]        chord_size,
  output logic              song_done
);

  localparam logic [1:0]        MAX_CS   = 2'(MAX_NOTES);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [5:0]        note_nxt, dur_nxt;
  logic [1:0]        size_nxt;
  logic              load_nxt, act_nxt, done_nxt;
  logic              last_q, last_nxt, end_q, end_nxt;

  logic [5:0] rom_note, rom_dur;
  logic       rom_last, unused_rsvd;

  assign rom_note    = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur     = rom_data[DUR_MSB:DUR_LSB];
  assign rom_last    = rom_data[LAST_BIT];
  assign unused_rsvd = ^rom_data[2:0];

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    note_nxt  = note_to_load;
    dur_nxt   = duration;
    size_nxt  = chord_size;
    load_nxt  = 1'b0;
    act_nxt   = 1'b0;
    done_nxt  = song_done;
    last_nxt  = last_q;
    end_nxt   = end_q;
    unique case (state)
      S_IDLE:  if (play) state_nxt = S_FETCH;
      S_FETCH: if (play) state_nxt = S_WAIT;
      S_WAIT: begin
        if (play) begin
          if (rom_dur == END_DURATION) begin
            if (chord_size == 2'd0) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_PLAY;
              act_nxt   = 1'b1;
              end_nxt   = 1'b1;
            end
          end else begin
            note_nxt  = rom_note;
            dur_nxt   = rom_dur;
            last_nxt  = rom_last;
            size_nxt  = chord_size + 2'd1;
            load_nxt  = 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      // A strobe cut short by a pause is reissued before moving on.
      S_LOAD: begin
        if (play) begin
          if (load_new_note) state_nxt = S_GAP;
          else               load_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (play) begin
          if (last_q || chord_size == MAX_CS) begin
            state_nxt = S_PLAY;
            act_nxt   = 1'b1;
          end else if (rom_addr == ADDR_MAX) begin
            state_nxt = S_PLAY;
            act_nxt   = 1'b1;
            end_nxt   = 1'b1;
          end else begin
            addr_nxt  = rom_addr + ADDR_ONE;
            state_nxt = S_FETCH;
          end
        end
      end
      // Completion is consumed even if play falls in the same cycle.
      S_PLAY: begin
        if (note_done) begin
          size_nxt = 2'd0;
          if (end_q || rom_addr == ADDR_MAX) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt  = rom_addr + ADDR_ONE;
            state_nxt = S_FETCH;
          end
        end else begin
          act_nxt = play;
        end
      end
      S_DONE: begin
`ifdef CHORD_SEQ_LOOP_EN
        if (play) begin
          addr_nxt  = '0;
          size_nxt  = 2'd0;
          end_nxt   = 1'b0;
          done_nxt  = 1'b0;
          state_nxt = S_FETCH;
        end
`else
        done_nxt = 1'b1;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      rom_addr      <= '0;
      note_to_load  <= 6'd0;
      duration      <= 6'd0;
      chord_size    <= 2'd0;
      load_new_note <= 1'b0;
      activate      <= 1'b0;
      song_done     <= 1'b0;
      last_q        <= 1'b0;
      end_q         <= 1'b0;
    end else begin
      state         <= state_nxt;
      rom_addr      <= addr_nxt;
      note_to_load  <= note_nxt;
      duration      <= dur_nxt;
      chord_size    <= size_nxt;
      load_new_note <= load_nxt;
      activate      <= act_nxt;
      song_done     <= done_nxt;
      last_q        <= last_nxt;
      end_q         <= end_nxt;
    end
  end

endmodule

// File: tb/tb_chord_sequencer.sv
// Bench for chord_sequencer: song ROM and chord player models plus a song-level reference model.
module tb_chord_sequencer;

  localparam int ADDR_W    = 7;
  localparam int AMAX      = (1 << ADDR_W) - 1;
  localparam int MAX_NOTES = 3;

  logic              clk = 1'b0;
  logic              reset, play, note_done;
  logic [15:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [5:0]        note_to_load, duration;
  logic              load_new_note, activate, song_done;
  logic [1:0]        chord_size;

  always #5 clk = ~clk;

  chord_sequencer #(.ADDR_W(ADDR_W), .MAX_NOTES(MAX_NOTES)) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .rom_data      (rom_data),
    .note_done     (note_done),
    .rom_addr      (rom_addr),
    .note_to_load  (note_to_load),
    .duration      (duration),
    .load_new_note (load_new_note),
    .activate      (activate),
    .chord_size    (chord_size),
    .song_done     (song_done)
  );

  logic [15:0] rom [0:AMAX];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [5:0] note;
    logic [5:0] dur;
  } exp_t;

  exp_t exp_q[$];
  int   exp_sizes[$];
  int   first_size, exp_end_addr;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en = 1'b0, player_en = 1'b0, stale_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [15:0] mk_word(input logic last, input logic [5:0] note, input logic [5:0] dur);
    return {last, note, dur, 3'b000};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i <= AMAX; i++) rom[i] = 16'h0000;
  endtask

  task automatic fill_random(input bit markers);
    logic [5:0] d;
    for (int i = 0; i <= AMAX; i++) begin
      d = 6'($urandom_range(1, 63));
      if (markers && $urandom_range(0, 11) == 0) d = 6'd0;
      rom[i] = {1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)), d, 3'($urandom_range(0, 7))};
    end
  endtask

  // Song as a list of chords: close on last, on a full chord, on an end marker or at the top address.
  task automatic build_model();
    int addr, n;
    bit ended;
    logic [15:0] w;
    exp_q.delete();
    exp_sizes.delete();
    first_size = -1;
    addr  = 0;
    ended = 1'b0;
    while (!ended) begin
      n = 0;
      while (1) begin
        w = rom[addr];
        if (w[8:3] == 6'd0) begin ended = 1'b1; break; end
        exp_q.push_back({w[14:9], w[8:3]});
        n++;
        if (w[15] || n == MAX_NOTES) begin
          if (addr == AMAX) ended = 1'b1; else addr++;
          break;
        end
        if (addr == AMAX) begin ended = 1'b1; break; end
        addr++;
      end
      if (n > 0) exp_sizes.push_back(n);
      if (first_size < 0) first_size = n;
    end
    exp_end_addr = addr;
  endtask

  // Output monitor followed by the chord player model, both on the falling edge.
  int   since_load = 100, loads_in_chord = 0, pd_cnt = 0, sz;
  logic act_q = 1'b0;
  exp_t e;
  initial begin
    note_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        since_load++;
        if (load_new_note) begin
          check_eq("load_spacing", since_load >= 3, 1);
          check_eq("load_while_active", activate, 0);
          check_eq("load_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("load_note", note_to_load, e.note);
            check_eq("load_dur", duration, e.dur);
          end
          since_load = 0;
          loads_in_chord++;
        end
        if (activate && !act_q) begin
          check_eq("chord_expected", exp_sizes.size() > 0, 1);
          if (exp_sizes.size() > 0) begin
            sz = exp_sizes.pop_front();
            check_eq("chord_size", chord_size, sz);
            check_eq("chord_loads", loads_in_chord, sz);
          end
          loads_in_chord = 0;
        end
        if (act_q && note_done) check_eq("act_fall", activate, 0);
        if (song_done) check_eq("done_act", activate, 0);
      end else begin
        since_load     = 100;
        loads_in_chord = 0;
      end
      act_q = activate;
      note_done = 1'b0;
      if (player_en && activate) begin
        if (pd_cnt == 0) note_done = 1'b1;
        else pd_cnt--;
      end else begin
        pd_cnt = $urandom_range(0, 4);
        if (stale_en && !activate && $urandom_range(0, 3) == 0) note_done = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    play  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_addr"}, rom_addr, 0);
    check_eq({pfx, "_note"}, note_to_load, 0);
    check_eq({pfx, "_dur"}, duration, 0);
    check_eq({pfx, "_load"}, load_new_note, 0);
    check_eq({pfx, "_act"}, activate, 0);
    check_eq({pfx, "_size"}, chord_size, 0);
    check_eq({pfx, "_done"}, song_done, 0);
  endtask

  task automatic run_song(input bit stale);
    int cyc;
    bit seen;
    build_model();
    mon_en = 1'b0; player_en = 1'b0; stale_en = 1'b0;
    do_reset();
    mon_en = 1'b1; player_en = 1'b1; stale_en = stale;
    play = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!song_done && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
      if (activate && !seen) begin
        seen = 1'b1;
        if (first_size > 0) check_eq("act_latency", cyc, 4 * first_size + 1);
      end
    end
    play = 1'b0;
    stale_en = 1'b0;
    check_eq("song_done", song_done, 1);
    check_eq("end_addr", rom_addr, exp_end_addr);
    check_eq("act_at_end", activate, 0);
    check_eq("loads_left", exp_q.size(), 0);
    check_eq("chords_left", exp_sizes.size(), 0);
  endtask

  initial begin
    int cyc, strobes;
    reset = 1'b1;
    play  = 1'b0;
    clear_rom();
    do_reset();
    check_reset_vals("rst");

    clear_rom();
    rom[0] = mk_word(1'b0, 6'd36, 6'd4);
    rom[1] = mk_word(1'b0, 6'd32, 6'd4);
    rom[2] = mk_word(1'b1, 6'd30, 6'd4);
    run_song(1'b0);

    // Four notes without last; the second is a rest.
    clear_rom();
    rom[0] = mk_word(1'b0, 6'd5, 6'd3);
    rom[1] = mk_word(1'b0, 6'd0, 6'd7);
    rom[2] = mk_word(1'b0, 6'd9, 6'd2);
    rom[3] = mk_word(1'b0, 6'd11, 6'd6);
    run_song(1'b1);

    clear_rom();
    rom[0] = mk_word(1'b1, 6'd7, 6'd9);
    mon_en = 1'b0; player_en = 1'b0; stale_en = 1'b0;
    do_reset();
    play = 1'b1;
    cyc  = 0;
    while (!load_new_note && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("pause_load_seen", load_new_note, 1);
    play = 1'b0;
    strobes = 0;
    repeat (5) begin
      @(posedge clk);
      #1 strobes += int'(load_new_note);
    end
    check_eq("pause_no_strobe", strobes, 0);
    check_eq("pause_addr", rom_addr, 0);
    check_eq("pause_size", chord_size, 1);
    play = 1'b1;
    strobes = 0;
    repeat (6) begin
      @(posedge clk);
      #1 strobes += int'(load_new_note);
    end
    check_eq("resume_one_strobe", strobes, 1);
    check_eq("resume_note", note_to_load, 7);
    check_eq("resume_dur", duration, 9);
    player_en = 1'b1;
    cyc = 0;
    while (!song_done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("pause_song_done", song_done, 1);
    play = 1'b0;

    clear_rom();
    rom[0] = mk_word(1'b0, 6'd10, 6'd5);
    rom[1] = mk_word(1'b1, 6'd20, 6'd6);
    mon_en = 1'b0; player_en = 1'b0;
    do_reset();
    play = 1'b1;
    cyc  = 0;
    while (!activate && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("mid_act", activate, 1);
    check_eq("mid_size", chord_size, 2);
    reset = 1'b1;
    @(posedge clk);
    #1 check_reset_vals("mid_rst");
    reset = 1'b0;
    play  = 1'b0;

    for (int s = 0; s < 5; s++) begin
      fill_random(1'b1);
      run_song(1'b1);
    end

    // No end marker anywhere: the song must stop at the top address.
    fill_random(1'b0);
    run_song(1'b1);
`ifdef CHORD_SEQ_LOOP_EN
    mon_en = 1'b0; player_en = 1'b0;
    play = 1'b1;
    @(posedge clk);
    #1 check_eq("loop_addr", rom_addr, 0);
    check_eq("loop_done_pulse", song_done, 0);
    play = 1'b0;
`else
    play = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("done_sticky", song_done, 1);
    check_eq("done_addr", rom_addr, AMAX);
    play = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
